// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined reduction tree (reduce_tree_pipe).
// apply_op works on a 64-bit container; callers cast to and from their own word width.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND      = 2'b00,
        OP_OR       = 2'b01,
        OP_XOR      = 2'b10,
        OP_FULL_AND = 2'b11
    } reduce_op_e;

    localparam int MAX_WIDTH = 64;

    function automatic int levels(input int port_num);
        return $clog2(port_num);
    endfunction

    // FULL_AND combines like AND inside the tree; only the final output squeezes it to one bit.
    function automatic logic [MAX_WIDTH-1:0] apply_op(input reduce_op_e op,
                                                      input logic [MAX_WIDTH-1:0] a,
                                                      input logic [MAX_WIDTH-1:0] b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: folds IN_WORDS words pairwise into IN_WORDS/2 and registers
// data, op and valid. The whole stage advances only when en is high.
module reduce_stage #(
    parameter int IN_WORDS = 2,
    parameter int WIDTH    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic [1:0]                        in_op,
    input  logic [IN_WORDS*WIDTH-1:0]         in_data,
    output logic                              out_valid,
    output logic [1:0]                        out_op,
    output logic [(IN_WORDS/2)*WIDTH-1:0]     out_data
);
    import reduce_pkg::*;

    localparam int OUT_WORDS = IN_WORDS / 2;

    logic                        valid_q, valid_d;
    logic [1:0]                  op_q, op_d;
    logic [OUT_WORDS*WIDTH-1:0]  data_q, data_d;
    logic [OUT_WORDS*WIDTH-1:0]  comb_data;

    always_comb begin
        comb_data = '0;
        for (int k = 0; k < OUT_WORDS; k++) begin
            comb_data[k*WIDTH +: WIDTH] = WIDTH'(apply_op(reduce_op_e'(in_op),
                                                          64'(in_data[(2*k)*WIDTH +: WIDTH]),
                                                          64'(in_data[(2*k+1)*WIDTH +: WIDTH])));
        end
    end

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        if (en) begin
            valid_d = in_valid;
            op_d    = in_op;
            data_d  = comb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= 2'b00;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_data  = data_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined PORT_NUM-input reducer (AND/OR/XOR/FULL_AND) with valid/ready on both sides.
// Define REDUCE_TREE_STATS_EN to add the saturating accepted-result counter out_count.
module reduce_tree_pipe #(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PORT_NUM*WIDTH-1:0]   in_data,
    input  logic [1:0]                  in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_q
`ifdef REDUCE_TREE_STATS_EN
    ,
    output logic [15:0]                 out_count
`endif
);
    import reduce_pkg::*;

    localparam int LEVELS = levels(PORT_NUM);

    // Handshake: a beat moves on a cycle where valid && ready. The whole pipe
    // (bubbles included) moves together on adv, so in_ready is simply adv.
    logic adv;

    logic                       s0_valid_q, s0_valid_d;
    logic [1:0]                 s0_op_q, s0_op_d;
    logic [PORT_NUM*WIDTH-1:0]  s0_data_q, s0_data_d;

    logic [1:0]                 last_op;
    logic [WIDTH-1:0]           last_data;

    always_comb begin
        adv        = !out_valid || out_ready;
        in_ready   = adv;
        s0_valid_d = s0_valid_q;
        s0_op_d    = s0_op_q;
        s0_data_d  = s0_data_q;
        if (adv) begin
            s0_valid_d = in_valid;
            s0_op_d    = in_op;
            s0_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= 2'b00;
            s0_data_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_op_q    <= s0_op_d;
            s0_data_q  <= s0_data_d;
        end
    end

    for (genvar i = 1; i <= LEVELS; i++) begin : g_lvl
        localparam int IW = PORT_NUM >> (i - 1);
        logic                       valid;
        logic [1:0]                 op;
        logic [(IW/2)*WIDTH-1:0]    data;

        if (i == 1) begin : g_first
            reduce_stage #(.IN_WORDS(IW), .WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (adv),
                .in_valid  (s0_valid_q),
                .in_op     (s0_op_q),
                .in_data   (s0_data_q),
                .out_valid (valid),
                .out_op    (op),
                .out_data  (data)
            );
        end else begin : g_next
            reduce_stage #(.IN_WORDS(IW), .WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (adv),
                .in_valid  (g_lvl[i-1].valid),
                .in_op     (g_lvl[i-1].op),
                .in_data   (g_lvl[i-1].data),
                .out_valid (valid),
                .out_op    (op),
                .out_data  (data)
            );
        end
    end

    assign out_valid = g_lvl[LEVELS].valid;
    assign last_op   = g_lvl[LEVELS].op;
    assign last_data = g_lvl[LEVELS].data;

    // The tree ran FULL_AND as AND; collapsing the surviving word finishes the full reduction.
    always_comb begin
        out_q = '0;
        if (out_valid) begin
            if (reduce_op_e'(last_op) == OP_FULL_AND) begin
                out_q[0] = &last_data;
            end else begin
                out_q = last_data;
            end
        end
    end

`ifdef REDUCE_TREE_STATS_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (out_valid && out_ready && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Bench for reduce_tree_pipe: directed vectors on an 8x8 and 8x7 instance, plus a
// randomized stall sweep on 2/4/16-port instances against a plain arithmetic model.
module tb_reduce_tree_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Index 0: PORT_NUM=8; 1: 2; 2: 4; 3: 16. All WIDTH=8.
    logic         in_valid_a  [4];
    logic         in_ready_a  [4];
    logic [127:0] in_data_a   [4];
    logic [1:0]   in_op_a     [4];
    logic         out_valid_a [4];
    logic         out_ready_a [4];
    logic [7:0]   out_q_a     [4];
`ifdef REDUCE_TREE_STATS_EN
    logic [15:0]  out_count_a [4];
    logic [15:0]  w7_out_count;
`endif

    logic         w7_in_valid;
    logic         w7_in_ready;
    logic [55:0]  w7_in_data;
    logic [1:0]   w7_in_op;
    logic         w7_out_valid;
    logic         w7_out_ready;
    logic [6:0]   w7_out_q;

    reduce_tree_pipe #(.PORT_NUM(8), .WIDTH(7)) u_w7 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w7_in_valid),
        .in_ready  (w7_in_ready),
        .in_data   (w7_in_data),
        .in_op     (w7_in_op),
        .out_valid (w7_out_valid),
        .out_ready (w7_out_ready),
        .out_q     (w7_out_q)
`ifdef REDUCE_TREE_STATS_EN
        ,
        .out_count (w7_out_count)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_reduce(input logic [127:0] d, input int pn, input logic [1:0] op);
        logic [7:0] acc;
        logic       all_ones;
        case (op)
            2'b00: begin acc = 8'hFF; for (int k = 0; k < pn; k++) acc &= d[k*8 +: 8]; end
            2'b01: begin acc = 8'h00; for (int k = 0; k < pn; k++) acc |= d[k*8 +: 8]; end
            2'b10: begin acc = 8'h00; for (int k = 0; k < pn; k++) acc ^= d[k*8 +: 8]; end
            default: begin
                all_ones = 1'b1;
                for (int b = 0; b < pn * 8; b++) all_ones &= d[b];
                acc = {7'b0, all_ones};
            end
        endcase
        return acc;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUTs and per-DUT scoreboards ----------------
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int PN = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 4 : 16;

        logic [7:0] exp_q[$];
        logic       stall_prev = 1'b0;
        logic [7:0] hold_q = 8'h00;
        logic [7:0] exp_v;

        reduce_tree_pipe #(.PORT_NUM(PN), .WIDTH(8)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g][PN*8-1:0]),
            .in_op     (in_op_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_q     (out_q_a[g])
`ifdef REDUCE_TREE_STATS_EN
            ,
            .out_count (out_count_a[g])
`endif
        );

        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check($sformatf("stall_valid_p%0d", PN), out_valid_a[g], 1);
                    check($sformatf("stall_hold_p%0d", PN), out_q_a[g], hold_q);
                end
                if (!out_valid_a[g]) begin
                    check($sformatf("idle_q_zero_p%0d", PN), out_q_a[g], 0);
                end else if (out_ready_a[g]) begin
                    check($sformatf("sb_nonempty_p%0d", PN), exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        check($sformatf("sb_out_p%0d", PN), out_q_a[g], exp_v);
                    end
                end
                stall_prev = out_valid_a[g] && !out_ready_a[g];
                hold_q     = out_q_a[g];
                if (in_valid_a[g] && in_ready_a[g]) begin
                    exp_q.push_back(ref_reduce(in_data_a[g], PN, in_op_a[g]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One beat into instance 0 on an idle pipe, then measure accept-to-out_valid latency.
    task automatic send_and_wait(input logic [63:0] d, input logic [1:0] op,
                                 input logic [7:0] exp, input string name);
        int lat;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = {64'h0, d};
        in_op_a[0]    = op;
        @(negedge clk);
        check({name, "_in_ready"}, in_ready_a[0], 1);
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (lat < 20 && !out_valid_a[0]) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 4);
        check(name, out_q_a[0], exp);
    endtask

    typedef struct {
        logic [63:0] data;
        logic [1:0]  op;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        vec_t         vecs[8];
        logic [7:0]   exp4[4];
        logic [127:0] d;
        bit           pend[4];
        int           lat;
        int           extra;

        vecs[0] = '{64'h8040201008040201, 2'b01, 8'hFF, "onehot_or"};
        vecs[1] = '{64'h8040201008040201, 2'b10, 8'hFF, "onehot_xor"};
        vecs[2] = '{64'h8040201008040201, 2'b00, 8'h00, "onehot_and"};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 2'b00, 8'hFF, "ones_and"};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 2'b11, 8'h01, "ones_full_and"};
        vecs[5] = '{64'hFFFFFFFFFFFFFF7F, 2'b11, 8'h00, "one_zero_full_and"};
        vecs[6] = '{64'h0F0F0F0F0F0F0F0F, 2'b10, 8'h00, "even_xor"};
        vecs[7] = '{64'hF0F0F0F0F0F0F0F1, 2'b10, 8'h01, "odd_xor"};

        for (int g = 0; g < 4; g++) begin
            in_valid_a[g]  = 1'b0;
            in_data_a[g]   = '0;
            in_op_a[g]     = 2'b00;
            out_ready_a[g] = 1'b1;
            pend[g]        = 1'b0;
        end
        w7_in_valid  = 1'b0;
        w7_in_data   = '0;
        w7_in_op     = 2'b00;
        w7_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid_a[0], 0);
        check("rst_out_q", out_q_a[0], 0);
        check("rst_in_ready", in_ready_a[0], 1);
        check("rst_w7_out_valid", w7_out_valid, 0);
`ifdef REDUCE_TREE_STATS_EN
        check("rst_out_count", out_count_a[0], 0);
`endif

        // FULL_AND on the 7-bit instance: result 7'h01 four cycles after accept.
        @(posedge clk); #1;
        w7_in_valid = 1'b1;
        w7_in_data  = {8{7'h7F}};
        w7_in_op    = 2'b11;
        @(negedge clk);
        check("w7_in_ready", w7_in_ready, 1);
        @(posedge clk); #1;
        w7_in_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !w7_out_valid) begin
            @(negedge clk);
            lat++;
        end
        check("w7_full_and_latency", lat, 4);
        check("w7_full_and", w7_out_q, 7'h01);

        for (int i = 0; i < 8; i++) begin
            send_and_wait(vecs[i].data, vecs[i].op, vecs[i].exp, vecs[i].name);
        end

        // Back-to-back beats, one per op, must come out on four consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            d = {64'h0, $urandom(), $urandom()};
            in_valid_a[0] = 1'b1;
            in_data_a[0]  = d;
            in_op_a[0]    = 2'(i);
            exp4[i]       = ref_reduce(d, 8, 2'(i));
            @(negedge clk);
            check("b2b_in_ready", in_ready_a[0], 1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                @(posedge clk); #1;
                in_valid_a[0] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("b2b_valid_%0d", i), out_valid_a[0], 1);
            check($sformatf("b2b_q_%0d", i), out_q_a[0], exp4[i]);
        end

        // Three beats in flight, downstream stalled for five cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) out_ready_a[0] = 1'b0;
            d = {64'h0, $urandom(), $urandom()};
            in_valid_a[0] = 1'b1;
            in_data_a[0]  = d;
            in_op_a[0]    = 2'(i);
            exp4[i]       = ref_reduce(d, 8, 2'(i));
            @(negedge clk);
            check("stall_fill_in_ready", in_ready_a[0], 1);
        end
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        lat = 0;
        while (lat < 10 && !out_valid_a[0]) begin
            @(negedge clk);
            lat++;
        end
        check("stall_first_valid", out_valid_a[0], 1);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check("stall_q_stable", out_q_a[0], exp4[0]);
            check("stall_in_ready_low", in_ready_a[0], 0);
        end
        @(posedge clk); #1;
        out_ready_a[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_release_valid_%0d", i), out_valid_a[0], 1);
            check($sformatf("stall_release_q_%0d", i), out_q_a[0], exp4[i]);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_a[0]) extra++;
        end
        check("stall_no_dup", extra, 0);

        // Reset with two beats in flight.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid_a[0] = 1'b1;
            in_data_a[0]  = {64'h0, $urandom(), $urandom()};
            in_op_a[0]    = 2'b01;
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid_a[0], 0);
        check("midrst_out_q", out_q_a[0], 0);
`ifdef REDUCE_TREE_STATS_EN
        check("midrst_out_count", out_count_a[0], 0);
`endif
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_a[0]) extra++;
        end
        check("midrst_no_stale", extra, 0);
        for (int i = 0; i < 3; i++) begin
            d = {64'h0, $urandom(), $urandom()};
            send_and_wait(d[63:0], 2'(i + 1), ref_reduce(d, 8, 2'(i + 1)), "post_rst");
        end
`ifdef REDUCE_TREE_STATS_EN
        @(negedge clk);
        check("count_after_three", out_count_a[0], 3);
`endif

        // Random sweep on the 2/4/16-port instances with stalls on both sides.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int g = 1; g < 4; g++) begin
                if (!pend[g]) begin
                    in_valid_a[g] = ($urandom_range(0, 3) != 0);
                    in_data_a[g]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                    in_op_a[g]    = 2'($urandom_range(0, 3));
                end
                out_ready_a[g] = (c % 300 < 150) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            for (int g = 1; g < 4; g++) pend[g] = in_valid_a[g] && !in_ready_a[g];
        end
        @(posedge clk); #1;
        for (int g = 1; g < 4; g++) begin
            in_valid_a[g]  = 1'b0;
            out_ready_a[g] = 1'b1;
        end
        repeat (40) @(negedge clk);
        check("drain_p8", g_dut[0].exp_q.size(), 0);
        check("drain_p2", g_dut[1].exp_q.size(), 0);
        check("drain_p4", g_dut[2].exp_q.size(), 0);
        check("drain_p16", g_dut[3].exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
